// File: rtl/sd_block_responder.sv
// sd_block_responder: target side of the sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_* sector protocol.
// Each accepted request moves one 512-byte sector between the core's sector buffer and a
// byte-wide backing store reached through a simple req/ack port (BRAM, SDRAM wrapper, model).
// Loads copy store -> buffer, saves copy buffer -> store, one byte at a time.

module sd_block_responder #(
    parameter int unsigned LBA_BITS  = 6,
    parameter int unsigned ACK_DELAY = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset,

    // Initiator request side
    input  logic [31:0]           sd_lba,
    input  logic                  sd_rd,
    input  logic                  sd_wr,
    output logic                  sd_ack,

    // Core sector buffer
    output logic [8:0]            sd_buff_addr,
    output logic [7:0]            sd_buff_dout,
    output logic                  sd_buff_wr,
    input  logic [7:0]            sd_buff_din,

    // Backing store
    output logic [LBA_BITS+8:0]   mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack,

    output logic                  busy
);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRdReq,
        StRdPut,
        StWrAddr,
        StWrLat,
        StWrReq,
        StDone
    } state_e;

    localparam logic [3:0] DelayInit = 4'(ACK_DELAY);

    state_e                state;
    logic [LBA_BITS-1:0]   lba;
    logic                  is_load;
    logic [8:0]            byte_cnt;
    logic [3:0]            delay_cnt;

    logic [8:0]            byte_next;
    logic                  last_byte;

    // Sector numbers wrap modulo 2^LBA_BITS, so the upper request bits are deliberately dropped.
    logic                  unused_lba_hi;

    assign unused_lba_hi = ^sd_lba[31:LBA_BITS];

    // Byte sequencing helpers shared by both transfer directions.
    always_comb begin
        byte_next = byte_cnt + 9'd1;
        last_byte = (byte_cnt == 9'd511);
    end

    // Transfer sequencer; every protocol output is a register updated alongside the state.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= StIdle;
            lba          <= '0;
            is_load      <= 1'b0;
            byte_cnt     <= 9'd0;
            delay_cnt    <= 4'd0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= 9'd0;
            sd_buff_dout <= 8'd0;
            sd_buff_wr   <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_wdata    <= 8'd0;
            busy         <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    // Request levels are only looked at here; a read wins over a write.
                    if (sd_rd || sd_wr) begin
                        lba       <= sd_lba[LBA_BITS-1:0];
                        is_load   <= sd_rd;
                        byte_cnt  <= 9'd0;
                        delay_cnt <= DelayInit;
                        sd_ack    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= StWait;
                    end
                end

                StWait: begin
                    // Counts down the acknowledge delay; the final cycle launches byte 0.
                    if (delay_cnt != 4'd0) begin
                        delay_cnt <= delay_cnt - 4'd1;
                    end else if (is_load) begin
                        mem_addr <= {lba, byte_cnt};
                        mem_rd   <= 1'b1;
                        state    <= StRdReq;
                    end else begin
                        sd_buff_addr <= byte_cnt;
                        state        <= StWrAddr;
                    end
                end

                StRdReq: begin
                    // Read data is only valid in the ack cycle, so it goes straight to the buffer.
                    if (mem_ack) begin
                        mem_rd       <= 1'b0;
                        sd_buff_addr <= byte_cnt;
                        sd_buff_dout <= mem_rdata;
                        sd_buff_wr   <= 1'b1;
                        state        <= StRdPut;
                    end
                end

                StRdPut: begin
                    sd_buff_wr <= 1'b0;
                    if (last_byte) begin
                        byte_cnt <= 9'd0;
                        sd_ack   <= 1'b0;
                        state    <= StDone;
                    end else begin
                        byte_cnt <= byte_next;
                        mem_addr <= {lba, byte_next};
                        mem_rd   <= 1'b1;
                        state    <= StRdReq;
                    end
                end

                StWrAddr: begin
                    // Buffer address is presented; its data arrives one cycle later.
                    state <= StWrLat;
                end

                StWrLat: begin
                    mem_wdata <= sd_buff_din;
                    mem_addr  <= {lba, byte_cnt};
                    mem_wr    <= 1'b1;
                    state     <= StWrReq;
                end

                StWrReq: begin
                    if (mem_ack) begin
                        mem_wr <= 1'b0;
                        if (last_byte) begin
                            byte_cnt <= 9'd0;
                            sd_ack   <= 1'b0;
                            state    <= StDone;
                        end else begin
                            byte_cnt     <= byte_next;
                            sd_buff_addr <= byte_next;
                            state        <= StWrAddr;
                        end
                    end
                end

                StDone: begin
                    // One extra low cycle so the initiator's edge detector sees sd_ack fall.
                    busy  <= 1'b0;
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_responder.sv
// Bench for sd_block_responder: req/ack backing-store model with fixed, random or zero latency,
// a registered sector-buffer model, and queue scoreboards for buffer strobes and store writes.

module tb_sd_block_responder;

    localparam int LBA_BITS  = 6;
    localparam int ACK_DELAY = 2;
    localparam int STORE     = 1 << (LBA_BITS + 9);

    logic                clk_sys = 1'b0;
    logic                reset;
    logic [31:0]         sd_lba;
    logic                sd_rd;
    logic                sd_wr;
    logic                sd_ack;
    logic [8:0]          sd_buff_addr;
    logic [7:0]          sd_buff_dout;
    logic                sd_buff_wr;
    logic [7:0]          sd_buff_din;
    logic [LBA_BITS+8:0] mem_addr;
    logic                mem_rd;
    logic                mem_wr;
    logic [7:0]          mem_wdata;
    logic [7:0]          mem_rdata;
    logic                mem_ack;
    logic                busy;

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    sd_block_responder #(
        .LBA_BITS  (LBA_BITS),
        .ACK_DELAY (ACK_DELAY)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .busy         (busy)
    );

    // ---------------- backing store model ----------------
    logic [7:0] store [STORE];
    logic       filled    = 1'b0;
    logic       ack_q     = 1'b0;
    logic [7:0] rdata_q   = 8'd0;
    int         wait_cnt  = 0;
    int         cur_lat   = 1;
    int         lat       = 1;
    logic       rand_lat  = 1'b0;
    logic       comb_mode = 1'b0;
    logic       spur_en   = 1'b0;

    function automatic logic [7:0] init_byte(input int a);
        if (a < 512) return 8'(a) ^ 8'h5A;
        return 8'(a * 37 + (a >> 9) * 11 + 3);
    endfunction

    assign mem_ack   = comb_mode ? (mem_rd | mem_wr) : ack_q;
    assign mem_rdata = comb_mode ? store[mem_addr] : rdata_q;

    always @(posedge clk_sys) begin
        if (!filled) begin
            for (int i = 0; i < STORE; i++) store[i] = init_byte(i);
            filled = 1'b1;
        end
        ack_q <= 1'b0;
        if (reset) begin
            wait_cnt = 0;
        end else if (comb_mode) begin
            if (mem_wr) store[mem_addr] = mem_wdata;
        end else if ((mem_rd || mem_wr) && !ack_q) begin
            if (wait_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(20, 1)) : lat;
            wait_cnt++;
            if (wait_cnt >= cur_lat) begin
                ack_q    <= 1'b1;
                wait_cnt = 0;
                if (mem_rd) rdata_q <= store[mem_addr];
                else store[mem_addr] = mem_wdata;
            end
        end else if (spur_en && !busy && $urandom_range(3, 0) == 0) begin
            ack_q   <= 1'b1;
            rdata_q <= 8'hEE;
        end
    end

    // Sector buffer model: content ~addr, one cycle read latency.
    always @(posedge clk_sys) sd_buff_din <= ~sd_buff_addr[7:0];

    // ---------------- scoreboard / monitor ----------------
    logic [16:0]         load_q [$];
    logic [22:0]         save_q [$];
    int                  buff_wr_cnt = 0;
    int                  wr_ack_cnt  = 0;
    logic [LBA_BITS+8:0] last_rd_addr = '0;
    logic                prev_req = 1'b0;
    logic                prev_ack = 1'b0;
    logic [LBA_BITS+8:0] prev_addr = '0;
    logic [7:0]          prev_wdata = '0;

    always @(negedge clk_sys) begin
        logic [16:0] exp_l;
        logic [22:0] exp_s;
        if (sd_buff_wr) begin
            buff_wr_cnt++;
            total++;
            if (load_q.size() == 0) begin
                bad++;
                $display("FAIL buff_strobe: unexpected strobe addr=%0d dout=%h, none expected",
                         sd_buff_addr, sd_buff_dout);
            end else begin
                exp_l = load_q.pop_front();
                if ({sd_buff_addr, sd_buff_dout} !== exp_l) begin
                    bad++;
                    $display("FAIL buff_data: got addr=%0d dout=%h, expected addr=%0d dout=%h",
                             sd_buff_addr, sd_buff_dout, exp_l[16:8], exp_l[7:0]);
                end
            end
            total++;
            if (sd_ack !== 1'b1) begin
                bad++;
                $display("FAIL buff_wr_ack: sd_ack=%b during strobe, expected 1", sd_ack);
            end
        end
        if (mem_wr && mem_ack) begin
            wr_ack_cnt++;
            total++;
            if (save_q.size() == 0) begin
                bad++;
                $display("FAIL mem_write: unexpected write addr=%h data=%h", mem_addr, mem_wdata);
            end else begin
                exp_s = save_q.pop_front();
                if ({mem_addr, mem_wdata} !== exp_s) begin
                    bad++;
                    $display("FAIL mem_write: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr, mem_wdata, exp_s[22:8], exp_s[7:0]);
                end
            end
        end
        if (mem_rd && mem_ack) last_rd_addr = mem_addr;
        total++;
        if (mem_rd && mem_wr) begin
            bad++;
            $display("FAIL mem_excl: mem_rd=%b mem_wr=%b, expected not both", mem_rd, mem_wr);
        end
        total++;
        if (sd_ack && !busy) begin
            bad++;
            $display("FAIL busy_ack: busy=%b while sd_ack=1, expected 1", busy);
        end
        if (prev_req && !prev_ack && (mem_rd || mem_wr)) begin
            total++;
            if (mem_addr !== prev_addr || (mem_wr && mem_wdata !== prev_wdata)) begin
                bad++;
                $display("FAIL mem_stable: addr=%h wdata=%h, expected addr=%h wdata=%h",
                         mem_addr, mem_wdata, prev_addr, prev_wdata);
            end
        end
        prev_req   = mem_rd | mem_wr;
        prev_ack   = mem_ack;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
    end

    // ---------------- initiator helpers ----------------
    task automatic push_load(input logic [LBA_BITS-1:0] sec);
        logic [LBA_BITS+8:0] a;
        for (int i = 0; i < 512; i++) begin
            a = {sec, 9'(i)};
            load_q.push_back({9'(i), store[a]});
        end
    endtask

    task automatic start_xfer(input logic rd, input logic wr, input logic [31:0] lba,
                              output int low_cnt);
        int n = 0;
        low_cnt = 0;
        sd_lba = lba;
        sd_rd  = rd;
        sd_wr  = wr;
        do begin
            @(negedge clk_sys);
            n++;
            if (!sd_ack && !busy) low_cnt++;
        end while (!sd_ack && n < 100);
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        total++;
        if (sd_ack !== 1'b1) begin
            bad++;
            $display("FAIL ack_rise: sd_ack=%b after %0d cycles, expected 1", sd_ack, n);
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sd_ack && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        total++;
        if (sd_ack !== 1'b0) begin
            bad++;
            $display("FAIL ack_fall: sd_ack=%b after %0d cycles, expected 0", sd_ack, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        sd_lba = 32'd0;
        repeat (3) @(negedge clk_sys);
        total++;
        if ({sd_ack, sd_buff_wr, mem_rd, mem_wr, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: ack/wr/rd/wr/busy=%b, expected 00000",
                     {sd_ack, sd_buff_wr, mem_rd, mem_wr, busy});
        end
        total++;
        if (sd_buff_addr !== 9'd0) begin
            bad++;
            $display("FAIL reset_baddr: got %0d, expected 0", sd_buff_addr);
        end
        total++;
        if (mem_addr !== '0) begin
            bad++;
            $display("FAIL reset_maddr: got %h, expected 0", mem_addr);
        end
        total++;
        if ({sd_buff_dout, mem_wdata} !== 16'd0) begin
            bad++;
            $display("FAIL reset_data: got %h, expected 0000", {sd_buff_dout, mem_wdata});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_load_basic;
        int c0 = buff_wr_cnt;
        int lc;
        lat = 1;
        for (int i = 0; i < 512; i++) load_q.push_back({9'(i), 8'(i) ^ 8'h5A});
        start_xfer(1'b1, 1'b0, 32'd0, lc);
        wait_done(3000);
        total++;
        if (buff_wr_cnt - c0 != 512) begin
            bad++;
            $display("FAIL load_count: got %0d strobes, expected 512", buff_wr_cnt - c0);
        end
        total++;
        if (load_q.size() != 0) begin
            bad++;
            $display("FAIL load_left: %0d expected strobes missing, expected 0", load_q.size());
        end
        repeat (2) @(negedge clk_sys);
        total++;
        if ({sd_ack, busy} !== 2'b00) begin
            bad++;
            $display("FAIL load_end: sd_ack/busy=%b, expected 00", {sd_ack, busy});
        end
    endtask

    task automatic test_save;
        int   c0 = wr_ack_cnt;
        int   errs = 0;
        int   lc;
        logic late_wr = 1'b0;
        logic [7:0] v;
        for (int i = 0; i < 512; i++) begin
            v = ~8'(i);
            save_q.push_back({15'(3 * 512 + i), v});
        end
        start_xfer(1'b0, 1'b1, 32'd3, lc);
        wait_done(4000);
        total++;
        if (wr_ack_cnt - c0 != 512 || save_q.size() != 0) begin
            bad++;
            $display("FAIL save_count: got %0d writes (%0d left), expected 512 (0 left)",
                     wr_ack_cnt - c0, save_q.size());
        end
        for (int i = 0; i < 512; i++) begin
            v = ~8'(i);
            if (store[15'(3 * 512 + i)] !== v) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL save_store: %0d wrong bytes in sector 3, expected 0", errs);
        end
        repeat (10) begin
            @(negedge clk_sys);
            if (mem_wr) late_wr = 1'b1;
        end
        total++;
        if (late_wr !== 1'b0) begin
            bad++;
            $display("FAIL save_late_wr: mem_wr seen after sd_ack fell, expected none");
        end
    endtask

    task automatic test_both_and_wrap;
        int c0 = wr_ack_cnt;
        int lc;
        push_load(6'd40);
        start_xfer(1'b1, 1'b1, 32'd40, lc);
        wait_done(3000);
        total++;
        if (load_q.size() != 0 || wr_ack_cnt != c0) begin
            bad++;
            $display("FAIL both_req: %0d loads left, %0d writes, expected 0 and 0",
                     load_q.size(), wr_ack_cnt - c0);
        end
        repeat (3) @(negedge clk_sys);
        push_load(6'd5);
        start_xfer(1'b1, 1'b0, 32'd69, lc);
        wait_done(3000);
        total++;
        if (load_q.size() != 0 || last_rd_addr !== {6'd5, 9'd511}) begin
            bad++;
            $display("FAIL lba_wrap: %0d left, last addr=%h, expected 0 and %h",
                     load_q.size(), last_rd_addr, {6'd5, 9'd511});
        end
    endtask

    task automatic test_reset_abort;
        int c0 = wr_ack_cnt;
        int c1;
        int n = 0;
        int lc;
        logic [7:0] v;
        for (int i = 0; i < 512; i++) begin
            v = ~8'(i);
            save_q.push_back({6'd10, 9'(i), v});
        end
        start_xfer(1'b0, 1'b1, 32'd10, lc);
        while (wr_ack_cnt - c0 < 100 && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        total++;
        if (wr_ack_cnt - c0 < 100) begin
            bad++;
            $display("FAIL abort_reach: %0d writes, expected at least 100", wr_ack_cnt - c0);
        end
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        total++;
        if (sd_ack !== 1'b0) begin
            bad++;
            $display("FAIL abort_ack: sd_ack=%b, expected 0", sd_ack);
        end
        total++;
        if (mem_wr !== 1'b0) begin
            bad++;
            $display("FAIL abort_memwr: mem_wr=%b, expected 0", mem_wr);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_busy: busy=%b, expected 0", busy);
        end
        @(negedge clk_sys);
        reset = 1'b0;
        save_q.delete();
        c1 = wr_ack_cnt;
        repeat (5) @(negedge clk_sys);
        total++;
        if (wr_ack_cnt != c1) begin
            bad++;
            $display("FAIL abort_quiet: %0d writes after reset, expected 0", wr_ack_cnt - c1);
        end
        push_load(6'd7);
        start_xfer(1'b1, 1'b0, 32'd7, lc);
        n = 0;
        while (!mem_rd && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        total++;
        if (mem_rd !== 1'b1 || mem_addr !== {6'd7, 9'd0}) begin
            bad++;
            $display("FAIL restart_addr: mem_rd=%b addr=%h, expected 1 and %h",
                     mem_rd, mem_addr, {6'd7, 9'd0});
        end
        wait_done(3000);
        total++;
        if (load_q.size() != 0) begin
            bad++;
            $display("FAIL restart_left: %0d strobes missing, expected 0", load_q.size());
        end
    endtask

    task automatic test_jitter;
        int   c0 = buff_wr_cnt;
        int   lc;
        logic idle_req = 1'b0;
        rand_lat = 1'b1;
        spur_en  = 1'b1;
        repeat (30) begin
            @(negedge clk_sys);
            if (mem_rd || mem_wr || sd_buff_wr || busy) idle_req = 1'b1;
        end
        total++;
        if (idle_req !== 1'b0) begin
            bad++;
            $display("FAIL spur_idle: activity on spurious mem_ack, expected none");
        end
        for (int i = 0; i < 512; i++) load_q.push_back({9'(i), 8'(i) ^ 8'h5A});
        start_xfer(1'b1, 1'b0, 32'd0, lc);
        wait_done(20000);
        total++;
        if (buff_wr_cnt - c0 != 512 || load_q.size() != 0) begin
            bad++;
            $display("FAIL jitter_count: got %0d strobes (%0d left), expected 512 (0 left)",
                     buff_wr_cnt - c0, load_q.size());
        end
        spur_en  = 1'b0;
        rand_lat = 1'b0;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic test_chain;
        int c0 = buff_wr_cnt;
        int gap = 0;
        int lc;
        comb_mode = 1'b1;
        for (int s = 0; s < 64; s++) begin
            push_load(6'(s));
            start_xfer(1'b1, 1'b0, 32'(s), lc);
            if (s > 0) gap += lc;
            wait_done(5000);
        end
        total++;
        if (gap != 63) begin
            bad++;
            $display("FAIL chain_gap: %0d busy-low cycles between sectors, expected 63", gap);
        end
        total++;
        if (buff_wr_cnt - c0 != 64 * 512 || load_q.size() != 0) begin
            bad++;
            $display("FAIL chain_count: got %0d strobes (%0d left), expected 32768 (0 left)",
                     buff_wr_cnt - c0, load_q.size());
        end
        total++;
        if (last_rd_addr !== {6'd63, 9'd511}) begin
            bad++;
            $display("FAIL chain_last: last addr=%h, expected %h", last_rd_addr, {6'd63, 9'd511});
        end
        repeat (3) @(negedge clk_sys);
        comb_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_save();
        test_both_and_wrap();
        test_reset_abort();
        test_jitter();
        test_chain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
